// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder/writer: instruction formats, the
// opcodes that select them, and the writer's program-level states.
package instr_enc_pkg;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Every opcode not listed here (loads, OP-IMM, JALR, SYSTEM, ...) uses the I layout.
    function automatic fmt_e opcode_to_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_RTYPE:         fmt = FMT_R;
            default:          fmt = FMT_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: scatters fields and the immediate into the
// format chosen by the opcode and flags immediates the format cannot hold.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    fmt_e fmt;
    logic hi11_same;
    logic hi12_same;
    logic hi20_same;

    assign fmt = opcode_to_fmt(opcode);

    // The discarded upper bits must all copy the format's sign bit.
    assign hi11_same = (&imm[31:11]) || !(|imm[31:11]);
    assign hi12_same = (&imm[31:12]) || !(|imm[31:12]);
    assign hi20_same = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        // NOTE: both outputs get a default before the case so no path can infer a latch.
        word  = '0;
        legal = 1'b1;
        case (fmt)
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = hi11_same;
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = hi11_same;
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = hi12_same && !imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = hi20_same && !imm[0];
            end
            default: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Boot-loader program builder: encodes requests into RV32I words and writes
// them to instruction memory through a 2-entry buffer at a running address.
module instr_encoder_writer
    import instr_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                ERR_CNT_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_load,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    input  logic                 in_last,
    output logic                 mem_we,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 done
);

    state_e            state, state_nxt;
    logic [1:0]        occ, occ_nxt;
    logic [ADDR_W-1:0] wptr, ptr_eff;
    logic [ADDR_W-1:0] buf_addr [2];
    logic [31:0]       buf_word [2];
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept, push, pop, cfg_take;

    instr_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // Readiness comes only from registered state, never from mem_ready.
    assign in_ready  = !rst && (state != DRAIN) && (occ < 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign mem_we    = (occ != 2'd0);
    assign pop       = mem_we && mem_ready;
    assign mem_addr  = buf_addr[0];
    assign mem_wdata = buf_word[0];
    assign done      = (state == DONE);
    assign occ_nxt   = occ + 2'(push) - 2'(pop);

    // A load in IDLE takes effect before a same-cycle request picks its address.
    assign cfg_take = cfg_load && (state == IDLE);
    assign ptr_eff  = cfg_take ? (cfg_addr & ~ADDR_W'(3)) : wptr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : RUN;
            RUN:     if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (occ_nxt == 2'd0) state_nxt = DONE;
            DONE:    state_nxt = accept ? (in_last ? DRAIN : RUN) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            occ       <= 2'd0;
            wptr      <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_count <= '0;
            // NOTE: the buffer is two registers, not RAM, so it is cleared to give defined outputs.
            buf_addr[0] <= BASE_ADDR;
            buf_addr[1] <= BASE_ADDR;
            buf_word[0] <= '0;
            buf_word[1] <= '0;
        end else begin
            state     <= state_nxt;
            occ       <= occ_nxt;
            err_pulse <= accept && !enc_legal;
            if (accept && !enc_legal && (err_count != '1))
                err_count <= err_count + ERR_CNT_W'(1);
            if (push)
                wptr <= ptr_eff + ADDR_W'(4);
            else if (cfg_take)
                wptr <= ptr_eff;

            // Head only changes on a pop or when filling an empty buffer.
            if (pop) begin
                if (push) begin
                    buf_addr[0] <= ptr_eff;
                    buf_word[0] <= enc_word;
                end else begin
                    buf_addr[0] <= buf_addr[1];
                    buf_word[0] <= buf_word[1];
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    buf_addr[0] <= ptr_eff;
                    buf_word[0] <= enc_word;
                end else begin
                    buf_addr[1] <= ptr_eff;
                    buf_word[1] <= enc_word;
                end
            end
        end
    end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Inverse of the core's immediate extraction path: packs instruction fields plus a 32-bit immediate into a 32-bit RV32I instruction word and writes it into instruction memory at auto-incrementing addresses.
- Used by the test/boot loader path to build programs in instruction memory before the single-cycle core is released.
- Includes a range/alignment check per format, a 2-entry output buffer and a memory-write handshake.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- ERR_CNT_W, 8, width of the saturating error counter.
- BASE_ADDR, 32'h0000_0000, write address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_load  in  1  load cfg_addr into the write pointer; honoured only in IDLE
- cfg_addr  in  ADDR_W  new start address; bits [1:0] are ignored and forced to 0
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  full signed immediate value; byte offset for B/J; upper-aligned value for U
- in_last  in  1  marks the final instruction of a program
- mem_we  out  1  write valid
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  encoded instruction
- err_pulse  out  1  one-cycle pulse when a request is rejected
- err_count  out  ERR_CNT_W  saturating count of rejected requests
- done  out  1  one-cycle pulse after the last write completes

Behaviour:
- Reset values: in_ready=0 during reset, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_pulse=0, err_count=0, done=0. Buffer is emptied and state=IDLE.
- Format from opcode:
  - 0100011 → S
  - 1100011 → B
  - 0110111 / 0010111 → U
  - 1101111 → J
  - 0110011 → R
  - anything else → I
- Packing:
  - I: imm[11:0] → [31:20]
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7]
  - B: imm[12] → [31], imm[10:5] → [30:25], imm[4:1] → [11:8], imm[11] → [7]
  - U: imm[31:12] → [31:12]
  - J: imm[20] → [31], imm[10:1] → [30:21], imm[11] → [20], imm[19:12] → [19:12]
  - rd, rs1, rs2, funct3 and funct7 go in their standard positions for each format. Fields unused by a format are ignored.
  - R: funct7 → [31:25].
- Legality checks (any failure rejects the request):
  - I/S: imm[31:11] must be all equal.
  - B: imm[31:12] must be all equal and imm[0]=0.
  - J: imm[31:20] must be all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
- Rejected request:
  - It is accepted (handshake completes) and dropped; nothing is written.
  - err_pulse=1 on the following cycle.
  - err_count increments and saturates at all-ones.
  - in_last on a rejected request still ends the program.
- Buffer:
  - 2 entries of {addr, word}; occupancy 0..2.
  - in_ready = (state != DRAIN) && (occupancy < 2). It must not depend combinationally on mem_ready.
  - Head entry drives mem_addr/mem_wdata. mem_we = occupancy != 0.
  - Hold rule: while mem_we && !mem_ready, mem_addr and mem_wdata stay stable.
  - Push and pop in the same cycle leave occupancy unchanged.
- Latency: a legal request accepted in cycle N gives mem_we=1 in cycle N+1 with an empty buffer.
- Write pointer:
  - Advances by 4 per legal accepted request. It is captured into the entry at accept time.
  - Wraps modulo 2^ADDR_W silently.
- FSM:
  - IDLE:
    - cfg_load loads the pointer.
    - An accepted request → RUN. If that request has in_last=1 → DRAIN.
    - cfg_load and in_valid in the same cycle: cfg_load applies first, and the request uses the new address.
  - RUN:
    - Accepting a request with in_last=1 → DRAIN.
    - cfg_load is ignored.
  - DRAIN:
    - in_ready=0.
    - When occupancy reaches 0 → DONE.
  - DONE: done=1 for one cycle, then IDLE. The pointer keeps its value, so the next program continues from there unless cfg_load is used.
- Reset mid-operation discards buffered writes. No partial write is issued after reset.

Decomposition:
- Package instr_enc_pkg:
  - fmt_e enum: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
  - Opcode constants: OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE.
  - state_e enum: IDLE, RUN, DRAIN, DONE.
  - Function opcode_to_fmt.
- One sub-module: instr_pack. It is purely combinational (fields + imm → word, legal flag). The writer FSM, buffer and counters stay in the top.

Test Plan:
- Round trip: encode I addi imm=-1, S imm=-2048, B imm=4094, U imm=32'hABCDE000, J imm=-1048576. Each written word, fed through the core's immediate generator, must give back the same imm, and mem_wdata must match the assembler reference (e.g. addi x1,x0,-1 = 32'hFFF00093).
- Illegal values: B imm=3, I imm=2048, U imm=32'h0000_1001. Each gives err_pulse, err_count=3, and no mem_we for these requests. The pointer is unchanged.
- Backpressure: 5 legal requests with mem_ready held 0 for 6 cycles. in_ready drops after 2 accepts, mem_addr/mem_wdata stay stable, and after release the writes go to addresses 0, 4, 8, 12, 16 in order.
- Program end: cfg_load cfg_addr=32'h100 with 3 requests, last one in_last=1. Writes go to 0x100, 0x104, 0x108. done pulses exactly one cycle after the last write handshake, and in_ready is 0 while in DRAIN.
- Reset mid-run: assert rst with 2 entries buffered and mem_ready=0. Next cycle mem_we=0, mem_addr=BASE_ADDR, err_count=0, and no stale write occurs.
- Saturation/wrap: 300 illegal requests give err_count=255. cfg_addr=32'hFFFF_FFFC followed by 2 writes gives addresses FFFF_FFFC, 0000_0000.
